// File: rtl/dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_defs (package)
// Brief    : Shared widths, arbiter state encoding and a constant clog2 used
//            for tag and FIFO pointer widths.
// Revision : 1.0 - initial release
// ============================================================================
package dma_defs;

  localparam int DMA_AW = 21;
  localparam int DMA_DW = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } dma_state_t;

  // Ceiling log2, never less than 1 so a 1-entry structure still gets a bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_tag_fifo
// Brief    : Small synchronous FIFO of requester tags, one entry per accepted
//            transfer that has not yet ended. Push and pop may coincide.
// Revision : 1.0 - initial release
// ============================================================================
module dma_tag_fifo
  import dma_defs::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  // A push into a full FIFO is only legal when the head leaves the same cycle
  assign w_push  = i_push & (~w_full | i_pop);
  assign w_pop   = i_pop & ~w_empty;

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rptr];

  // Tag storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_arbiter
// Brief    : Round-robin arbiter sharing the single memory-DMA port among
//            NREQ requesters, with bounded bursts and an in-order tag FIFO
//            that routes each completion back to its issuer.
// Revision : 1.0 - initial release
// ============================================================================
module dma_arbiter
  import dma_defs::*;
#(
  parameter int NREQ  = 4,
  parameter int BURST = 8,
  parameter int OUTST = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_rnw,
  input  logic [NREQ*DMA_AW-1:0] req_addr,
  input  logic [NREQ*DMA_DW-1:0] req_wd,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        req_end,
  output logic [DMA_DW-1:0]      req_rd,
  output logic                   dma_req,
  output logic                   dma_rnw,
  output logic [DMA_AW-1:0]      dma_addr,
  output logic [DMA_DW-1:0]      dma_wd,
  input  logic                   dma_ack,
  input  logic                   dma_end,
  input  logic [DMA_DW-1:0]      dma_rd,
  output logic                   busy,
  output logic                   err_stray
);

  localparam int TW = clog2(NREQ);

  dma_state_t       r_state;
  logic [TW-1:0]    r_g;
  logic [TW-1:0]    r_last;
  logic [7:0]       r_count;
  logic             r_err;

  logic [DMA_AW-1:0] w_addr [NREQ];
  logic [DMA_DW-1:0] w_wd   [NREQ];
  logic [TW-1:0]     w_pick;
  logic              w_found;
  logic              w_grant;
  logic              w_dma_req;
  logic              w_accept;
  logic              w_pop;
  logic              w_stray;
  logic              w_full;
  logic              w_empty;
  logic [TW-1:0]     w_head;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_addr[i] = req_addr[i*DMA_AW +: DMA_AW];
    assign w_wd[i]   = req_wd[i*DMA_DW +: DMA_DW];
  end

  assign w_grant   = (r_state == GRANT);
  // Stalling on a full FIFO keeps the grant; the requester simply waits
  assign w_dma_req = w_grant & req[r_g] & ~w_full;
  assign w_accept  = w_dma_req & dma_ack;
  assign w_pop     = dma_end & ~w_empty;
  assign w_stray   = dma_end & w_empty;

  // Datapath is zeroed outside GRANT so idle outputs are all quiet
  assign dma_req   = w_dma_req;
  assign dma_rnw   = w_grant & req_rnw[r_g];
  assign dma_addr  = w_grant ? w_addr[r_g] : '0;
  assign dma_wd    = w_grant ? w_wd[r_g]   : '0;
  assign req_rd    = w_pop ? dma_rd : '0;
  assign busy      = w_grant | ~w_empty;
  assign err_stray = r_err;

  // Round-robin search starting just after the previous grantee
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[(int'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_pick  = TW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // One-hot acknowledge to the grantee and completion to the FIFO head
  always_comb begin
    req_ack = '0;
    req_end = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ack[i] = w_accept && (r_g == TW'(i));
      req_end[i] = w_pop && (w_head == TW'(i));
    end
  end

  // Arbitration state machine with burst counter and sticky stray flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_last  <= TW'(NREQ - 1);
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_stray) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_g     <= w_pick;
            r_last  <= w_pick;
            r_count <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) begin
            r_count <= r_count + 8'd1;
            if (r_count + 8'd1 == 8'(BURST)) r_state <= IDLE;
          end else if (!req[r_g]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dma_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_data  (r_g),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_arbiter
// Brief    : Self-checking bench for dma_arbiter; expected acks and ends are
//            queued by the stimulus and retired by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_arbiter;
  import dma_defs::*;

  localparam int NREQ  = 4;
  localparam int BURST = 8;
  localparam int OUTST = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_rnw;
  logic [NREQ*DMA_AW-1:0] req_addr;
  logic [NREQ*DMA_DW-1:0] req_wd;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        req_end;
  logic [DMA_DW-1:0]      req_rd;
  logic                   dma_req;
  logic                   dma_rnw;
  logic [DMA_AW-1:0]      dma_addr;
  logic [DMA_DW-1:0]      dma_wd;
  logic                   dma_ack;
  logic                   dma_end;
  logic [DMA_DW-1:0]      dma_rd;
  logic                   busy;
  logic                   err_stray;

  typedef struct {
    int         tag;
    logic [7:0] data;
  } end_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   q_ack[$];
  end_t q_end[$];

  dma_arbiter #(
    .NREQ  (NREQ),
    .BURST (BURST),
    .OUTST (OUTST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_rnw   (req_rnw),
    .req_addr  (req_addr),
    .req_wd    (req_wd),
    .req_ack   (req_ack),
    .req_end   (req_end),
    .req_rd    (req_rd),
    .dma_req   (dma_req),
    .dma_rnw   (dma_rnw),
    .dma_addr  (dma_addr),
    .dma_wd    (dma_wd),
    .dma_ack   (dma_ack),
    .dma_end   (dma_end),
    .dma_rd    (dma_rd),
    .busy      (busy),
    .err_stray (err_stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: retires queued expectations whenever the DUT pulses ack or end
  always @(negedge clk) begin
    #2;
    if (req_ack !== '0) begin
      n_tests++;
      if (q_ack.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got %b expected none", req_ack);
      end else begin
        int t;
        t = q_ack.pop_front();
        if (req_ack !== 4'(1 << t)) begin
          n_fail++;
          $display("FAIL ack_tag: got %b expected %b", req_ack, 4'(1 << t));
        end
      end
    end
    if (req_end !== '0) begin
      n_tests++;
      if (q_end.size() == 0) begin
        n_fail++;
        $display("FAIL end_unexpected: got %b expected none", req_end);
      end else begin
        end_t e;
        e = q_end.pop_front();
        if (req_end !== 4'(1 << e.tag) || req_rd !== e.data) begin
          n_fail++;
          $display("FAIL end_tag: got end=%b rd=%h expected end=%b rd=%h",
                   req_end, req_rd, 4'(1 << e.tag), e.data);
        end
      end
    end
  end

  task automatic do_reset(input logic [3:0] hold_req, input bit check);
    step();
    rst = 1'b1; req = hold_req; req_rnw = '0;
    dma_ack = 1'b0; dma_end = 1'b0; dma_rd = '0;
    step();
    #1;
    if (check) begin
      chk("reset_outputs", {7'd0, dma_req, dma_rnw, dma_addr, dma_wd, req_ack, req_end, req_rd,
                            busy, err_stray} != '0, 0);
      chk("reset_busy", busy, 0);
    end
    step();
    rst = 1'b0; req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks, ends, gaps;
    bit pend;
    rst = 1'b1; req = '0; req_rnw = '0; dma_ack = 1'b0; dma_end = 1'b0; dma_rd = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*DMA_AW +: DMA_AW] = 21'h100000 | 21'(i);
      req_wd[i*DMA_DW +: DMA_DW]   = 8'hC0 | 8'(i);
    end
    req_addr[1*DMA_AW +: DMA_AW] = 21'h12345;

    // 1: single read from requester 1
    do_reset(4'hF, 1);
    step(); req = 4'b0010; req_rnw = 4'b0010;
    #1 chk("t1_idle_dma_req", dma_req, 0);
    step(); dma_ack = 1'b1; q_ack.push_back(1); q_end.push_back('{1, 8'hA5});
    #1 chk("t1_dma_req", dma_req, 1);
    chk("t1_dma_addr", dma_addr, 21'h12345);
    chk("t1_dma_rnw", dma_rnw, 1);
    step(); dma_ack = 1'b0; req = '0; dma_end = 1'b1; dma_rd = 8'hA5;
    #1 chk("t1_req_rd", req_rd, 8'hA5);
    chk("t1_req_end", req_end, 4'b0010);
    step(); dma_end = 1'b0;
    #1 chk("t1_busy_after", busy, 0);

    // 2: all four requesting, ack every cycle, end one cycle later
    do_reset(4'h0, 0);
    acks = 0; ends = 0; gaps = 0; pend = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      step();
      if (cyc == 0) begin req = 4'hF; dma_ack = 1'b1; end
      dma_end = pend;
      if (pend) begin
        q_end.push_back('{(ends / 8) % 4, 8'(ends)});
        dma_rd = 8'(ends);
        ends++;
      end
      if (acks == 40) begin req = '0; dma_ack = 1'b0; end
      #1;
      pend = 0;
      if (acks < 40) begin
        if (dma_req) begin
          q_ack.push_back((acks / 8) % 4);
          acks++;
          pend = 1;
        end else if (acks > 0) begin
          gaps++;
        end
      end
      if (acks == 40 && !pend && ends == 40) break;
    end
    step(); dma_end = 1'b0;
    chk("t2_acks", acks, 40);
    chk("t2_ends", ends, 40);
    chk("t2_rotation_gaps", gaps, 4);

    // 3/4: FIFO full stall, ack+end together while full, in-order ends
    do_reset(4'h0, 0);
    step(); req = 4'b0001;
    step(); dma_ack = 1'b1; q_ack.push_back(0); q_end.push_back('{0, 8'h11});
    #1 chk("t3_first_req", dma_req, 1);
    step(); dma_ack = 1'b0; req = 4'b0010;
    #1 chk("t3_release", dma_req, 0);
    step();
    #1 chk("t3_idle_gap", dma_req, 0);
    step(); dma_ack = 1'b1; q_ack.push_back(1); q_end.push_back('{1, 8'h22});
    #1 chk("t3_grant1_req", dma_req, 1);
    step();
    #1 chk("t3_full_stall", dma_req, 0);
    chk("t3_full_busy", busy, 1);
    chk("t3_full_no_ack", req_ack, 0);
    step(); dma_end = 1'b1; dma_rd = 8'h11;
    #1 chk("t4_full_ack_end_req", dma_req, 0);
    step(); dma_end = 1'b0; q_ack.push_back(1); q_end.push_back('{1, 8'h33});
    #1 chk("t3_reassert", dma_req, 1);
    step(); dma_ack = 1'b0; dma_end = 1'b1; dma_rd = 8'h22;
    #1 chk("t4_refull_stall", dma_req, 0);
    step(); req = '0; dma_rd = 8'h33;
    step(); dma_end = 1'b0;
    #1 chk("t4_drained_busy", busy, 0);

    // 5: requester 2 withdraws, pending requester 3 gets the next grant
    do_reset(4'h0, 0);
    step(); req = 4'b0100;
    step(); req = 4'b1000;
    #1 chk("t5_withdraw_req", dma_req, 0);
    step();
    #1 chk("t5_idle_busy", busy, 0);
    step(); dma_ack = 1'b1; q_ack.push_back(3); q_end.push_back('{3, 8'h5A});
    #1 chk("t5_grant3_addr", dma_addr, 21'h100003);
    chk("t5_grant3_wd", dma_wd, 8'hC3);
    chk("t5_grant3_rnw", dma_rnw, 0);
    step(); dma_ack = 1'b0; req = '0; dma_end = 1'b1; dma_rd = 8'h5A;
    step(); dma_end = 1'b0;

    // 6: stray end, then reset with transfers outstanding
    do_reset(4'h0, 0);
    step(); dma_end = 1'b1; dma_rd = 8'h77;
    #1 chk("t6_stray_rd", req_rd, 0);
    step(); dma_end = 1'b0;
    #1 chk("t6_err_set", err_stray, 1);
    step(); req = 4'b0001;
    #1 chk("t6_err_sticky", err_stray, 1);
    step(); dma_ack = 1'b1; q_ack.push_back(0);
    step(); q_ack.push_back(0);
    step(); dma_ack = 1'b0;
    #1 chk("t6_full_busy", busy, 1);
    step(); rst = 1'b1;
    step(); dma_end = 1'b1; dma_rd = 8'h99;
    #1 chk("t6_rst_outputs", {7'd0, dma_req, dma_rnw, dma_addr, dma_wd, req_ack, req_end, req_rd,
                              busy, err_stray} != '0, 0);
    step(); dma_end = 1'b0; rst = 1'b0; req = '0;
    #1 chk("t6_err_cleared", err_stray, 0);
    chk("t6_busy_cleared", busy, 0);

    step(); step();
    chk("ack_queue_drained", q_ack.size(), 0);
    chk("end_queue_drained", q_end.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
